vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_pkg.sv | 22 ++
 rtl/vga_axis_cnt.sv | 47 ++++
 rtl/vga_timing_gen.sv | 109 ++++++++++
 tb/tb_vga_timing_gen.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Default 640x480@60 timing constants and helpers for deriving axis totals.
package vga_pkg;

   localparam int DEF_H_DISPLAY = 640;
   localparam int DEF_H_FRONT   = 16;
   localparam int DEF_H_SYNC    = 96;
   localparam int DEF_H_BACK    = 48;
   localparam int DEF_V_DISPLAY = 480;
   localparam int DEF_V_FRONT   = 10;
   localparam int DEF_V_SYNC    = 2;
   localparam int DEF_V_BACK    = 33;
   localparam int DEF_CNT_W     = 10;

   function automatic int h_total(input int display, input int front, input int sync, input int back);
      return display + front + sync + back;
   endfunction

   function automatic int v_total(input int display, input int front, input int sync, input int back);
      return display + front + sync + back;
   endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// Wrapping position counter with carry-out; the range flag is registered from
// the next count so it lines up with the count itself.
module vga_axis_cnt #(
   parameter int CNT_W    = 10,
   parameter int TOTAL    = 800,
   parameter int RANGE_LO = 656,
   parameter int RANGE_HI = 752
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             inc,
   output logic [CNT_W-1:0] count,
   output logic [CNT_W-1:0] count_next,
   output logic             carry,
   output logic             in_range
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);
   localparam logic [CNT_W-1:0] LO   = CNT_W'(RANGE_LO);
   localparam logic [CNT_W-1:0] HI   = CNT_W'(RANGE_HI);
   localparam logic RST_IN = (RANGE_LO == 0) && (RANGE_HI > 0);

   logic in_range_next;

   always_comb begin
      carry      = inc && (count == LAST);
      count_next = count;
      if (clear || carry) begin
         count_next = '0;
      end else if (inc) begin
         count_next = count + CNT_W'(1);
      end
      in_range_next = (count_next >= LO) && (count_next < HI);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count    <= '0;
         in_range <= RST_IN;
      end else begin
         count    <= count_next;
         in_range <= in_range_next;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, syncs, blanking and start pulses.
// Define VGA_TIMING_FRAME_CNT_EN to add the 8-bit frame_cnt output.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_DISPLAY  = DEF_H_DISPLAY,
   parameter int H_FRONT    = DEF_H_FRONT,
   parameter int H_SYNC     = DEF_H_SYNC,
   parameter int H_BACK     = DEF_H_BACK,
   parameter int V_DISPLAY  = DEF_V_DISPLAY,
   parameter int V_FRONT    = DEF_V_FRONT,
   parameter int V_SYNC     = DEF_V_SYNC,
   parameter int V_BACK     = DEF_V_BACK,
   parameter bit H_SYNC_POL = 1'b0,
   parameter bit V_SYNC_POL = 1'b0,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pix_en,
   input  logic             resync,
   output logic [CNT_W-1:0] pixel_x,
   output logic [CNT_W-1:0] pixel_y,
   output logic             hsync,
   output logic             vsync,
   output logic             video_on,
   output logic             line_start,
   output logic             frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
   ,
   output logic [7:0]       frame_cnt
`endif
);

   localparam int H_TOTAL = h_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
   localparam int V_TOTAL = v_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
   localparam logic [CNT_W-1:0] H_VIS = CNT_W'(H_DISPLAY);
   localparam logic [CNT_W-1:0] V_VIS = CNT_W'(V_DISPLAY);

   if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_size_check
      $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CNT_W bits");
   end

   logic [CNT_W-1:0] x_next;
   logic [CNT_W-1:0] y_next;
   logic             h_carry;
   logic             v_carry;
   logic             h_in_sync;
   logic             v_in_sync;

   vga_axis_cnt #(
      .CNT_W    (CNT_W),
      .TOTAL    (H_TOTAL),
      .RANGE_LO (H_DISPLAY + H_FRONT),
      .RANGE_HI (H_DISPLAY + H_FRONT + H_SYNC)
   ) u_h_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (resync),
      .inc        (pix_en),
      .count      (pixel_x),
      .count_next (x_next),
      .carry      (h_carry),
      .in_range   (h_in_sync)
   );

   // The vertical axis steps only on the horizontal wrap.
   vga_axis_cnt #(
      .CNT_W    (CNT_W),
      .TOTAL    (V_TOTAL),
      .RANGE_LO (V_DISPLAY + V_FRONT),
      .RANGE_HI (V_DISPLAY + V_FRONT + V_SYNC)
   ) u_v_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (resync),
      .inc        (h_carry),
      .count      (pixel_y),
      .count_next (y_next),
      .carry      (v_carry),
      .in_range   (v_in_sync)
   );

   assign hsync = h_in_sync ? H_SYNC_POL : ~H_SYNC_POL;
   assign vsync = v_in_sync ? V_SYNC_POL : ~V_SYNC_POL;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         video_on    <= 1'b1;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         video_on    <= (x_next < H_VIS) && (y_next < V_VIS);
         line_start  <= resync || h_carry;
         frame_start <= resync || v_carry;
      end
   end

`ifdef VGA_TIMING_FRAME_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frame_cnt <= 8'd0;
      end else if (resync || v_carry) begin
         frame_cnt <= frame_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance plus a tiny active-high-sync
// instance so whole frames fit in a short run.
module tb_vga_timing_gen;
   import vga_pkg::*;

   localparam int HD [2] = '{640, 8};
   localparam int HF [2] = '{16, 2};
   localparam int HS [2] = '{96, 3};
   localparam int HB [2] = '{48, 2};
   localparam int VD [2] = '{480, 4};
   localparam int VF [2] = '{10, 1};
   localparam int VS [2] = '{2, 2};
   localparam int VB [2] = '{33, 1};
   localparam bit POL [2] = '{1'b0, 1'b1};

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n  [2] = '{1'b0, 1'b0};
   logic       pix_en [2] = '{1'b1, 1'b1};
   logic       resync [2] = '{1'b0, 1'b0};
   logic [9:0] px [2];
   logic [9:0] py [2];
   logic       hs [2];
   logic       vs [2];
   logic       vid [2];
   logic       ls [2];
   logic       fs [2];
`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [7:0] fc [2];
`endif

   int checks = 0;
   int fails  = 0;
   logic [31:0] exp_q[$];

   vga_timing_gen u_dut_a (
      .clk(clk), .rst_n(rst_n[0]), .pix_en(pix_en[0]), .resync(resync[0]),
      .pixel_x(px[0]), .pixel_y(py[0]), .hsync(hs[0]), .vsync(vs[0]),
      .video_on(vid[0]), .line_start(ls[0]), .frame_start(fs[0])
`ifdef VGA_TIMING_FRAME_CNT_EN
      , .frame_cnt(fc[0])
`endif
   );

   vga_timing_gen #(
      .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
      .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .CNT_W(10)
   ) u_dut_b (
      .clk(clk), .rst_n(rst_n[1]), .pix_en(pix_en[1]), .resync(resync[1]),
      .pixel_x(px[1]), .pixel_y(py[1]), .hsync(hs[1]), .vsync(vs[1]),
      .video_on(vid[1]), .line_start(ls[1]), .frame_start(fs[1])
`ifdef VGA_TIMING_FRAME_CNT_EN
      , .frame_cnt(fc[1])
`endif
   );

   // Raster model: position advances modulo the totals; outputs follow from position.
   int mx [2];
   int my [2];
   bit mls [2];
   bit mfs [2];
   bit live [2] = '{1'b0, 1'b0};
   int mfc [2];

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rst_n[d] === 1'b0) begin
            mx[d] = 0; my[d] = 0; mls[d] = 0; mfs[d] = 0; mfc[d] = 0; live[d] = 1;
         end else if (resync[d] === 1'b1) begin
            mx[d] = 0; my[d] = 0; mls[d] = 1; mfs[d] = 1; mfc[d] = (mfc[d] + 1) % 256;
         end else if (pix_en[d] === 1'b1) begin
            mx[d] = (mx[d] + 1) % (HD[d] + HF[d] + HS[d] + HB[d]);
            if (mx[d] == 0) my[d] = (my[d] + 1) % (VD[d] + VF[d] + VS[d] + VB[d]);
            mls[d] = (mx[d] == 0);
            mfs[d] = (mx[d] == 0) && (my[d] == 0);
            if (mfs[d]) mfc[d] = (mfc[d] + 1) % 256;
         end else begin
            mls[d] = 0; mfs[d] = 0;
         end
      end
   end

   function automatic logic [24:0] model_vec(input int d);
      bit h_in, v_in, vis;
      h_in = (mx[d] >= HD[d] + HF[d]) && (mx[d] < HD[d] + HF[d] + HS[d]);
      v_in = (my[d] >= VD[d] + VF[d]) && (my[d] < VD[d] + VF[d] + VS[d]);
      vis  = (mx[d] < HD[d]) && (my[d] < VD[d]);
      return {10'(mx[d]), 10'(my[d]), h_in ? POL[d] : ~POL[d], v_in ? POL[d] : ~POL[d],
              vis, mls[d], mfs[d]};
   endfunction

   // scoreboard: per-cycle compare against the model
   logic [24:0] act_v, exp_v;
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (live[d]) begin
            act_v = {px[d], py[d], hs[d], vs[d], vid[d], ls[d], fs[d]};
            exp_v = model_vec(d);
            checks++;
            if (act_v !== exp_v) begin
               fails++;
               $display("FAIL model_cmp dut%0d t=%0t act x=%0d y=%0d hs/vs/vid/ls/fs=%b req x=%0d y=%0d hs/vs/vid/ls/fs=%b",
                        d, $time, act_v[24:15], act_v[14:5], act_v[4:0], exp_v[24:15], exp_v[14:5], exp_v[4:0]);
            end
`ifdef VGA_TIMING_FRAME_CNT_EN
            checks++;
            if (fc[d] !== 8'(mfc[d])) begin
               fails++;
               $display("FAIL frame_cnt dut%0d t=%0t act=%0d req=%0d", d, $time, fc[d], mfc[d]);
            end
`endif
         end
      end
   end

   // driver / literal-check tasks
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s act=%0d req=%0d", name, act, req);
      end
   endtask

   task automatic pop_chk(input string name, input int act);
      if (exp_q.size() == 0) begin
         chk({name, "_noexp"}, 0, 1);
      end else begin
         chk(name, act, int'(exp_q.pop_front()));
      end
   endtask

   task automatic wait_pos(input int d, input int x, input int y, input int budget);
      int n = 0;
      while (!(px[d] == 10'(x) && (y < 0 || py[d] == 10'(y))) && n < budget) begin
         tick(1); n++;
      end
      chk("wait_pos", int'(px[d] == 10'(x)), 1);
   endtask

   int n, period, low, fall, rise, vcnt, hcnt, vscnt;
`ifdef VGA_TIMING_FRAME_CNT_EN
   int fc0;
`endif

   initial begin
      tick(3);
      // reset values: both DUTs
      exp_q = '{0, 0, 1, 1, 1, 0, 0, 0, 0};
      pop_chk("rst_x", px[0]); pop_chk("rst_y", py[0]); pop_chk("rst_hs", hs[0]);
      pop_chk("rst_vs", vs[0]); pop_chk("rst_vid", vid[0]); pop_chk("rst_ls", ls[0]);
      pop_chk("rst_fs", fs[0]); pop_chk("rst_hs_b", hs[1]); pop_chk("rst_vs_b", vs[1]);
      rst_n[0] = 1; rst_n[1] = 1;
      tick(1);
      exp_q = '{1, 0};
      pop_chk("first_x", px[0]); pop_chk("first_ls", ls[0]);

      // first line wrap, then one full line of hsync geometry
      n = 0;
      while (!ls[0] && n < 1000) begin tick(1); n++; end
      chk("wait_ls", ls[0], 1);
      exp_q = '{1, 0};
      pop_chk("wrap_y", py[0]); pop_chk("wrap_fs", fs[0]);
      period = 0; low = 0; fall = -1; rise = -1;
      do begin
         if (hs[0] == 0 && fall < 0) fall = px[0];
         if (hs[0] == 1 && fall >= 0 && rise < 0) rise = px[0];
         low += (hs[0] == 0) ? 1 : 0;
         period++;
         tick(1);
      end while (!ls[0] && period < 2000);
      exp_q = '{800, 96, 656, 752};
      pop_chk("line_len", period); pop_chk("hs_low_cnt", low);
      pop_chk("hs_fall_x", fall); pop_chk("hs_rise_x", rise);

      // resync mid-line with pix_en low
      wait_pos(0, 300, -1, 1000);
      resync[0] = 1; pix_en[0] = 0;
      tick(1);
      exp_q = '{0, 0, 1, 1, 1};
      pop_chk("rs_x", px[0]); pop_chk("rs_y", py[0]); pop_chk("rs_ls", ls[0]);
      pop_chk("rs_fs", fs[0]); pop_chk("rs_vid", vid[0]);
      resync[0] = 0;
      tick(3);
      exp_q = '{0, 0};
      pop_chk("hold_x", px[0]); pop_chk("hold_ls", ls[0]);
      pix_en[0] = 1;

      // reset inside hsync overrides a simultaneous resync
      wait_pos(0, 700, -1, 1000);
      chk("hs_at_700", hs[0], 0);
      rst_n[0] = 0; resync[0] = 1;
      tick(1);
      exp_q = '{0, 0, 1, 1, 0, 0};
      pop_chk("mr_x", px[0]); pop_chk("mr_y", py[0]); pop_chk("mr_hs", hs[0]);
      pop_chk("mr_vs", vs[0]); pop_chk("mr_ls", ls[0]); pop_chk("mr_fs", fs[0]);
      rst_n[0] = 1; resync[0] = 0;
      tick(1);
      exp_q = '{1, 0};
      pop_chk("mr_next_x", px[0]); pop_chk("mr_next_ls", ls[0]);

      // small DUT: one full-rate frame of sync/visible counts
      n = 0;
      while (!fs[1] && n < 200) begin tick(1); n++; end
      chk("wait_fs_b", fs[1], 1);
      period = 0; vcnt = 0; hcnt = 0; vscnt = 0;
      do begin
         vcnt += vid[1]; hcnt += hs[1]; vscnt += vs[1];
         period++;
         tick(1);
      end while (!fs[1] && period < 400);
      exp_q = '{120, 32, 24, 30};
      pop_chk("frame_len_b", period); pop_chk("vid_cnt_b", vcnt);
      pop_chk("hs_hi_cnt_b", hcnt); pop_chk("vs_hi_cnt_b", vscnt);

      wait_pos(1, 6, 3, 200);
      resync[1] = 1;
      tick(1);
      exp_q = '{0, 0, 1, 1, 1};
      pop_chk("rs_x_b", px[1]); pop_chk("rs_y_b", py[1]); pop_chk("rs_ls_b", ls[1]);
      pop_chk("rs_fs_b", fs[1]); pop_chk("rs_vid_b", vid[1]);
      resync[1] = 0;

      // half-rate pixel enable doubles the frame period
      n = 0;
      do begin pix_en[1] = ~pix_en[1]; tick(1); n++; end while (!fs[1] && n < 500);
      chk("wait_fs_half", fs[1], 1);
      period = 0;
      do begin pix_en[1] = ~pix_en[1]; tick(1); period++; end while (!fs[1] && period < 600);
      chk("frame_len_half", period, 240);
      pix_en[1] = 1;

`ifdef VGA_TIMING_FRAME_CNT_EN
      n = 0;
      while (!fs[1] && n < 400) begin tick(1); n++; end
      fc0 = fc[1];
      tick(256 * 120);
      chk("fc_wrap_fs", fs[1], 1);
      chk("fc_wrap_val", fc[1], fc0);
`endif

      tick(5);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
